// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for the MIPS core: iterative 32-step shift-add multiply and
// restoring divide, plus MTHI/MTLO writes and MFHI/MFLO hazard stalling.
`ifndef MOVE_HIGH
`define MOVE_HIGH 2'b01
`endif
`ifndef MOVE_LOW
`define MOVE_LOW 2'b10
`endif

module muldiv_hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [1:0]  mf_req,
    output logic        op_ready,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] opnd_q;   // multiplicand or divisor magnitude
    logic [31:0] shf_q;    // multiplier, or dividend shifting into quotient
    logic [64:0] acc_q;
    logic [32:0] rem_q;
    logic        div_q;
    logic        neg_q;
    logic        neg_r_q;
    logic        dz_q;
    logic        busy_q;
    logic        ready_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [64:0] mul_nxt;
    logic [33:0] div_sh;
    logic [33:0] div_diff;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op_signed = ~op_code[0];
        mag_a     = (op_signed && src_a[31]) ? -src_a : src_a;
        mag_b     = (op_signed && src_b[31]) ? -src_b : src_b;

        mul_sum = acc_q[64:32] + (shf_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_nxt = {1'b0, mul_sum, acc_q[31:1]};

        // Borrow out of the 34-bit trial subtraction means "restore".
        div_sh   = {rem_q, shf_q[31]};
        div_diff = div_sh - {2'b00, opnd_q};
        if (div_diff[33]) begin
            rem_nxt = div_sh[32:0];
            quo_nxt = {shf_q[30:0], 1'b0};
        end else begin
            rem_nxt = div_diff[32:0];
            quo_nxt = {shf_q[30:0], 1'b1};
        end

        prod_fix = neg_q ? -acc_q[63:0] : acc_q[63:0];
        // Zero divisor leaves remainder = |a|; sign fix-up restores raw a.
        quo_fix  = dz_q ? '1 : (neg_q ? -shf_q : shf_q);
        rem_fix  = neg_r_q ? -rem_q[31:0] : rem_q[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            shf_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (op_valid) begin
                        case (op_code)
                            OP_MULT, OP_MULTU: begin
                                opnd_q  <= mag_a;
                                shf_q   <= mag_b;
                                neg_q   <= op_signed & (src_a[31] ^ src_b[31]);
                                acc_q   <= '0;
                                cnt_q   <= '0;
                                div_q   <= 1'b0;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                                state_q <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                opnd_q  <= mag_b;
                                shf_q   <= mag_a;
                                rem_q   <= '0;
                                neg_q   <= op_signed & (src_a[31] ^ src_b[31]);
                                neg_r_q <= op_signed & src_a[31];
                                dz_q    <= (src_b == '0);
                                cnt_q   <= '0;
                                div_q   <= 1'b1;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                                state_q <= S_DIV;
                            end
                            OP_MTHI: hi_q <= src_a;
                            OP_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= mul_nxt;
                    shf_q <= {1'b0, shf_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                        done_q  <= 1'b1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    shf_q <= quo_nxt;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                        done_q  <= 1'b1;
                    end
                end
                S_FIX: begin
                    if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign op_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hi_reg   = hi_q;
    assign lo_reg   = lo_q;
    assign stall    = busy_q && (op_valid || (mf_req == `MOVE_HIGH) || (mf_req == `MOVE_LOW));

endmodule
